// File: rtl/uart_frame_rx_pkg.sv
// Shared definitions for the UART frame receiver.
// Holds the FSM state encoding, which is also the o_Debug_State encoding.
// Also holds the frame length, the field offsets inside the frame and a
// 3-input majority helper. The helper is used only when
// UART_RX_MAJORITY_VOTE_EN is defined.
package uart_frame_rx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_START_BIT  = 3'd1,
      ST_DATA_BITS  = 3'd2,
      ST_STOP_BIT1  = 3'd3,
      ST_STOP_BIT2  = 3'd4,
      ST_STORE_BYTE = 3'd5,
      ST_FRAME_DONE = 3'd6,
      ST_ERROR      = 3'd7
   } state_t;

   localparam int FRAME_BYTES = 34;
   localparam int ADC1_MSB    = 271;
   localparam int ADC2_MSB    = 143;
   localparam int ENC_MSB     = 15;

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_frame_rx_byte.sv
// uart_byte_rx: receives one 8N2 character from an already-synchronised line.
//
// Ports:
//   i_Clk, i_Reset  clock, synchronous active-high reset
//   i_Rx            synchronised serial line (idle high)
//   i_Start         line seen low while the frame controller is idle
//   o_Byte          received data byte (LSB arrives first)
//   o_Byte_Done     stop bit 2 sampled high; o_Byte is valid this cycle
//   o_Bit_Error     a stop bit sampled low
//   o_Glitch        start bit sampled high at mid-bit; dropped silently
//   o_State         current state, for debug visibility
//
// Build option UART_RX_MAJORITY_VOTE_EN: each bit is the majority of three
// consecutive samples around mid-bit. Without it, the single middle sample is
// used. The decision is made on the same cycle in both builds, so timing
// does not change.
//
// state        | meaning
// -------------+------------------------------------------------------
// IDLE         | waiting for i_Start
// START_BIT    | timing to start-bit middle; high there means glitch
// DATA_BITS    | eight data bits, one decision per bit period
// STOP_BIT1    | first stop bit must be high
// STOP_BIT2    | second stop bit must be high; byte done or error
module uart_byte_rx
   import uart_frame_rx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 10
) (
   input  logic       i_Clk,
   input  logic       i_Reset,
   input  logic       i_Rx,
   input  logic       i_Start,
   output logic [7:0] o_Byte,
   output logic       o_Byte_Done,
   output logic       o_Bit_Error,
   output logic       o_Glitch,
   output state_t     o_State
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2);
   localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);

   state_t        st;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;
   logic          tick;
   logic          bit_val;

`ifdef UART_RX_MAJORITY_VOTE_EN
   // hist[0] is the mid-bit sample and hist[1] is the one before it.
   // i_Rx on the decision cycle gives the sample after mid-bit.
   logic [1:0] hist;
   always_ff @(posedge i_Clk) begin
      if (i_Reset) hist <= 2'b11;
      else         hist <= {hist[0], i_Rx};
   end
   assign bit_val = majority3(hist[1], hist[0], i_Rx);
`else
   logic hist;
   always_ff @(posedge i_Clk) begin
      if (i_Reset) hist <= 1'b1;
      else         hist <= i_Rx;
   end
   assign bit_val = hist;
`endif

   assign tick        = (cnt == '0);
   assign o_Byte      = shift;
   assign o_State     = st;
   assign o_Glitch    = (st == ST_START_BIT) && tick && bit_val;
   assign o_Bit_Error = ((st == ST_STOP_BIT1) || (st == ST_STOP_BIT2)) && tick && !bit_val;
   assign o_Byte_Done = (st == ST_STOP_BIT2) && tick && bit_val;

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         st      <= ST_IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shift   <= '0;
      end else begin
         case (st)
            ST_IDLE: begin
               if (i_Start) begin
                  st  <= ST_START_BIT;
                  cnt <= HALF_LOAD;
               end
            end
            ST_START_BIT: begin
               if (tick) begin
                  if (bit_val) begin
                     st <= ST_IDLE;
                  end else begin
                     st      <= ST_DATA_BITS;
                     cnt     <= BIT_LOAD;
                     bit_idx <= '0;
                  end
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            ST_DATA_BITS: begin
               if (tick) begin
                  shift <= {bit_val, shift[7:1]};
                  cnt   <= BIT_LOAD;
                  if (bit_idx == 3'd7) st <= ST_STOP_BIT1;
                  else                 bit_idx <= bit_idx + 3'd1;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            ST_STOP_BIT1: begin
               if (tick) begin
                  cnt <= BIT_LOAD;
                  st  <= bit_val ? ST_STOP_BIT2 : ST_IDLE;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            ST_STOP_BIT2: begin
               if (tick) st <= ST_IDLE;
               else      cnt <= cnt - CW'(1);
            end
            default: st <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_frame_rx.sv
// uart_frame_rx: rebuilds the 272-bit capture frame from an 8N2 UART stream.
// Also flags framing errors and abandons partial frames after an idle timeout.
//
// Ports:
//   i_Clk, i_Reset      clock, synchronous active-high reset
//   i_Rx_Serial         asynchronous UART line, idles high
//   o_Frame             last complete frame, byte k at [271-8k -: 8]
//   o_Adc_Data1/2       ADC channel fields of o_Frame
//   o_Encoder           encoder field of o_Frame
//   o_Frame_Valid       1-cycle pulse when o_Frame updates
//   o_Frame_Error       1-cycle pulse on a bad stop bit
//   o_Timeout           1-cycle pulse when a partial frame is abandoned
//   o_Byte_Count        bytes received so far in the current frame
//   o_Debug_State       encoded state (byte receiver state while a byte is in flight)
//
// Build option UART_RX_MAJORITY_VOTE_EN selects 3-sample voting in uart_byte_rx.
//
// state        | meaning
// -------------+------------------------------------------------------
// IDLE         | between bytes; timeout runs while a frame is partial
// START_BIT    | byte in flight inside uart_byte_rx (its state is shown)
// STORE_BYTE   | write byte at o_Byte_Count, advance count
// FRAME_DONE   | publish buffer to o_Frame, pulse o_Frame_Valid
// ERROR        | bad stop bit; wait for a full bit time of idle line
module uart_frame_rx
   import uart_frame_rx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 10,
   parameter int TIMEOUT_CLKS = 200
) (
   input  logic                     i_Clk,
   input  logic                     i_Reset,
   input  logic                     i_Rx_Serial,
   output logic [8*FRAME_BYTES-1:0] o_Frame,
   output logic [127:0]             o_Adc_Data1,
   output logic [127:0]             o_Adc_Data2,
   output logic [15:0]              o_Encoder,
   output logic                     o_Frame_Valid,
   output logic                     o_Frame_Error,
   output logic                     o_Timeout,
   output logic [5:0]               o_Byte_Count,
   output logic [2:0]               o_Debug_State
);

   localparam int FRAME_W = 8 * FRAME_BYTES;
   localparam int CNT_MAX = (TIMEOUT_CLKS > CLKS_PER_BIT) ? TIMEOUT_CLKS : CLKS_PER_BIT;
   localparam int CNT_W   = $clog2(CNT_MAX);
   localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TIMEOUT_CLKS - 1);
   localparam logic [CNT_W-1:0] BIT_LOAD = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [5:0]       LAST_IDX = 6'(FRAME_BYTES - 1);

   logic       rx_meta;
   logic       rx_sync;
   state_t     st;
   state_t     rx_state;
   logic [CNT_W-1:0] cnt;
   logic [7:0] frame_mem [FRAME_BYTES];
   logic [7:0] rx_byte;
   logic       rx_done;
   logic       rx_err;
   logic       rx_glitch;
   logic       rx_start;

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= i_Rx_Serial;
         rx_sync <= rx_meta;
      end
   end

   // A start edge takes priority over an expiring timeout in the same cycle.
   assign rx_start = (st == ST_IDLE) && !rx_sync;

   uart_byte_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte_rx (
      .i_Clk       (i_Clk),
      .i_Reset     (i_Reset),
      .i_Rx        (rx_sync),
      .i_Start     (rx_start),
      .o_Byte      (rx_byte),
      .o_Byte_Done (rx_done),
      .o_Bit_Error (rx_err),
      .o_Glitch    (rx_glitch),
      .o_State     (rx_state)
   );

   // The single cnt register is shared. In IDLE it is the inter-byte timeout.
   // In ERROR it counts the idle-high recovery time.
   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         st            <= ST_IDLE;
         cnt           <= TMO_LOAD;
         o_Frame       <= '0;
         o_Frame_Valid <= 1'b0;
         o_Frame_Error <= 1'b0;
         o_Timeout     <= 1'b0;
         o_Byte_Count  <= '0;
         for (int k = 0; k < FRAME_BYTES; k++) frame_mem[k] <= '0;
      end else begin
         o_Frame_Valid <= 1'b0;
         o_Frame_Error <= 1'b0;
         o_Timeout     <= 1'b0;
         case (st)
            ST_IDLE: begin
               if (!rx_sync) begin
                  st  <= ST_START_BIT;
                  cnt <= TMO_LOAD;
               end else if (o_Byte_Count != '0) begin
                  if (cnt == '0) begin
                     o_Timeout    <= 1'b1;
                     o_Byte_Count <= '0;
                     cnt          <= TMO_LOAD;
                  end else begin
                     cnt <= cnt - CNT_W'(1);
                  end
               end else begin
                  cnt <= TMO_LOAD;
               end
            end
            ST_START_BIT: begin
               if (rx_done) begin
                  st <= ST_STORE_BYTE;
               end else if (rx_err) begin
                  st            <= ST_ERROR;
                  o_Frame_Error <= 1'b1;
                  o_Byte_Count  <= '0;
                  cnt           <= BIT_LOAD;
               end else if (rx_glitch) begin
                  st <= ST_IDLE;
               end
            end
            ST_STORE_BYTE: begin
               frame_mem[o_Byte_Count] <= rx_byte;
               o_Byte_Count            <= o_Byte_Count + 6'd1;
               cnt                     <= TMO_LOAD;
               st <= (o_Byte_Count == LAST_IDX) ? ST_FRAME_DONE : ST_IDLE;
            end
            ST_FRAME_DONE: begin
               for (int k = 0; k < FRAME_BYTES; k++)
                  o_Frame[FRAME_W-1-8*k -: 8] <= frame_mem[k];
               o_Frame_Valid <= 1'b1;
               o_Byte_Count  <= '0;
               st            <= ST_IDLE;
            end
            ST_ERROR: begin
               if (!rx_sync) begin
                  cnt <= BIT_LOAD;
               end else if (cnt == '0) begin
                  st  <= ST_IDLE;
                  cnt <= TMO_LOAD;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: st <= ST_IDLE;
         endcase
      end
   end

   assign o_Adc_Data1   = o_Frame[ADC1_MSB -: 128];
   assign o_Adc_Data2   = o_Frame[ADC2_MSB -: 128];
   assign o_Encoder     = o_Frame[ENC_MSB -: 16];
   assign o_Debug_State = (st == ST_START_BIT) ? rx_state : st;

endmodule

// File: tb/tb_uart_frame_rx.sv
module tb_uart_frame_rx;

   localparam int CPB = 10;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         rx  = 1'b1;
   logic [271:0] o_Frame;
   logic [127:0] o_Adc_Data1;
   logic [127:0] o_Adc_Data2;
   logic [15:0]  o_Encoder;
   logic         o_Frame_Valid;
   logic         o_Frame_Error;
   logic         o_Timeout;
   logic [5:0]   o_Byte_Count;
   logic [2:0]   o_Debug_State;

   always #5 clk = ~clk;

   uart_frame_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(200)) dut (
      .i_Clk         (clk),
      .i_Reset       (rst),
      .i_Rx_Serial   (rx),
      .o_Frame       (o_Frame),
      .o_Adc_Data1   (o_Adc_Data1),
      .o_Adc_Data2   (o_Adc_Data2),
      .o_Encoder     (o_Encoder),
      .o_Frame_Valid (o_Frame_Valid),
      .o_Frame_Error (o_Frame_Error),
      .o_Timeout     (o_Timeout),
      .o_Byte_Count  (o_Byte_Count),
      .o_Debug_State (o_Debug_State)
   );

   typedef struct {
      logic [271:0] tx;
      logic [127:0] adc1;
      logic [127:0] adc2;
      logic [15:0]  enc;
      int           gap;
   } vec_t;

   vec_t vecs [4];
   int checks = 0;
   int errors = 0;
   int n_valid = 0;
   int n_err = 0;
   int n_tmo = 0;
   int pv, pe, pt;

   always @(negedge clk) begin
      if (!rst) begin
         if (o_Frame_Valid) n_valid++;
         if (o_Frame_Error) n_err++;
         if (o_Timeout)     n_tmo++;
      end
   end

   task automatic chk(input string name, input logic [271:0] act, input logic [271:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit bad_stop2);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx = 1'b1;
      repeat (CPB) @(negedge clk);
      rx = bad_stop2 ? 1'b0 : 1'b1;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
   endtask

   task automatic send_frame(input logic [271:0] f, input int nbytes, input int gap, input int bad_idx);
      logic [7:0] b;
      for (int k = 0; k < nbytes; k++) begin
         b = f[271-8*k -: 8];
         send_byte(b, k == bad_idx);
         repeat (gap) @(negedge clk);
      end
   endtask

   initial begin
      vecs[0].tx   = 272'h000102030405060708090a0b0c0d0e0f_101112131415161718191a1b1c1d1e1f_2021;
      vecs[0].adc1 = 128'h000102030405060708090a0b0c0d0e0f;
      vecs[0].adc2 = 128'h101112131415161718191a1b1c1d1e1f;
      vecs[0].enc  = 16'h2021;
      vecs[0].gap  = 0;
      vecs[1].tx   = 272'ha5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5_5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a_1234;
      vecs[1].adc1 = 128'ha5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5;
      vecs[1].adc2 = 128'h5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a;
      vecs[1].enc  = 16'h1234;
      vecs[1].gap  = 3;
      vecs[2].tx   = 272'hdeadbeef0123456789abcdeffedcba98_0f1e2d3c4b5a69788796a5b4c3d2e1f0_ffff;
      vecs[2].adc1 = 128'hdeadbeef0123456789abcdeffedcba98;
      vecs[2].adc2 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
      vecs[2].enc  = 16'hffff;
      vecs[2].gap  = 20;
      vecs[3].tx   = 272'hffffffffffffffffffffffffffffffff_00000000000000000000000000000000_8001;
      vecs[3].adc1 = 128'hffffffffffffffffffffffffffffffff;
      vecs[3].adc2 = 128'h0;
      vecs[3].enc  = 16'h8001;
      vecs[3].gap  = 0;

      rst = 1'b1;
      rx  = 1'b1;
      repeat (4) @(negedge clk);
      chk("reset_frame", o_Frame, 0);
      chk("reset_count", o_Byte_Count, 0);
      chk("reset_state", o_Debug_State, 0);
      chk("reset_pulses", {o_Frame_Valid, o_Frame_Error, o_Timeout}, 0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      for (int v = 0; v < 4; v++) begin
         pv = n_valid; pe = n_err; pt = n_tmo;
         send_frame(vecs[v].tx, 34, vecs[v].gap, -1);
         repeat (20) @(negedge clk);
         chk($sformatf("v%0d_valid_pulses", v), n_valid - pv, 1);
         chk($sformatf("v%0d_err_pulses", v), n_err - pe, 0);
         chk($sformatf("v%0d_tmo_pulses", v), n_tmo - pt, 0);
         chk($sformatf("v%0d_frame", v), o_Frame, vecs[v].tx);
         chk($sformatf("v%0d_byte0", v), o_Frame[271:264], vecs[v].tx[271:264]);
         chk($sformatf("v%0d_adc1", v), o_Adc_Data1, vecs[v].adc1);
         chk($sformatf("v%0d_adc2", v), o_Adc_Data2, vecs[v].adc2);
         chk($sformatf("v%0d_enc", v), o_Encoder, vecs[v].enc);
         chk($sformatf("v%0d_count", v), o_Byte_Count, 0);
      end

      // Partial frame abandoned by the inter-byte timeout.
      pv = n_valid; pt = n_tmo;
      send_frame(vecs[0].tx, 5, 0, -1);
      repeat (5) @(negedge clk);
      chk("tmo_count_before", o_Byte_Count, 5);
      repeat (245) @(negedge clk);
      chk("tmo_pulses", n_tmo - pt, 1);
      chk("tmo_count_after", o_Byte_Count, 0);
      chk("tmo_frame_held", o_Frame, vecs[3].tx);
      chk("tmo_no_valid", n_valid - pv, 0);
      send_frame(vecs[1].tx, 34, 0, -1);
      repeat (20) @(negedge clk);
      chk("tmo_next_valid", n_valid - pv, 1);
      chk("tmo_next_frame", o_Frame, vecs[1].tx);

      // Low second stop bit on byte 10.
      pv = n_valid; pe = n_err; pt = n_tmo;
      send_frame(vecs[2].tx, 11, 0, 10);
      repeat (20) @(negedge clk);
      chk("err_pulses", n_err - pe, 1);
      chk("err_count", o_Byte_Count, 0);
      chk("err_no_valid", n_valid - pv, 0);
      chk("err_frame_held", o_Frame, vecs[1].tx);
      chk("err_state_idle", o_Debug_State, 0);
      repeat (10) @(negedge clk);
      send_frame(vecs[2].tx, 34, 0, -1);
      repeat (20) @(negedge clk);
      chk("err_next_valid", n_valid - pv, 1);
      chk("err_next_frame", o_Frame, vecs[2].tx);
      chk("err_no_more_errs", n_err - pe, 1);
      chk("err_no_tmo", n_tmo - pt, 0);

      // 3-clock low glitch on the idle line with a partial frame pending.
      send_frame(vecs[0].tx, 3, 0, -1);
      repeat (10) @(negedge clk);
      pe = n_err; pt = n_tmo;
      rx = 1'b0;
      repeat (3) @(negedge clk);
      chk("glitch_in_start", o_Debug_State, 1);
      rx = 1'b1;
      repeat (20) @(negedge clk);
      chk("glitch_no_err", n_err - pe, 0);
      chk("glitch_state_idle", o_Debug_State, 0);
      chk("glitch_count_kept", o_Byte_Count, 3);
      repeat (250) @(negedge clk);
      chk("glitch_then_tmo", n_tmo - pt, 1);
      chk("glitch_tmo_count", o_Byte_Count, 0);

      // Reset in the middle of byte 20.
      send_frame(vecs[1].tx, 20, 0, -1);
      rx = 1'b0;
      repeat (25) @(negedge clk);
      chk("rst_pre_count", o_Byte_Count, 20);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_frame", o_Frame, 0);
      chk("rst_adc1", o_Adc_Data1, 0);
      chk("rst_enc", o_Encoder, 0);
      chk("rst_count", o_Byte_Count, 0);
      chk("rst_state", o_Debug_State, 0);
      chk("rst_pulses", {o_Frame_Valid, o_Frame_Error, o_Timeout}, 0);
      rst = 1'b0;
      rx  = 1'b1;
      repeat (30) @(negedge clk);
      pv = n_valid; pe = n_err;
      send_frame(vecs[3].tx, 34, 0, -1);
      repeat (20) @(negedge clk);
      chk("rst_next_valid", n_valid - pv, 1);
      chk("rst_next_frame", o_Frame, vecs[3].tx);
      chk("rst_next_no_err", n_err - pe, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
